cart_mmc1: RTL and testbench

MMC1-class (SxROM) cartridge mapper: the parametrised successor to the fixed-mapping NROM cart. It sits between the CPU/PPU cartridge buses and external synchronous PRG/CHR memories. It decodes serial CPU writes into control and bank registers, translates CPU/PPU addresses into banked memory addresses, and drives CIRAM enable and A10 according to a programmable mirroring mode.

---
 rtl/cart_pkg.sv | 25 ++
 rtl/cart_mmc1_if.sv | 31 +++
 rtl/mmc1_serial_regs.sv | 75 +++++++
 rtl/cart_mmc1.sv | 107 ++++++++++
 tb/tb_cart_mmc1.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_pkg.sv
// Shared constants for the MMC1-class cartridge mapper: mirroring and PRG
// mode encodings, serial register selects and the control reset value.
package cart_pkg;

  localparam logic [1:0] MIR_ONE_LO = 2'd0;
  localparam logic [1:0] MIR_ONE_HI = 2'd1;
  localparam logic [1:0] MIR_VERT   = 2'd2;
  localparam logic [1:0] MIR_HORZ   = 2'd3;

  // Modes 0 and 1 both select 32 KB switching.
  localparam logic [1:0] PRG_32K_A     = 2'd0;
  localparam logic [1:0] PRG_32K_B     = 2'd1;
  localparam logic [1:0] PRG_FIX_FIRST = 2'd2;
  localparam logic [1:0] PRG_FIX_LAST  = 2'd3;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CHR0 = 2'd1,
    REG_CHR1 = 2'd2,
    REG_PRG  = 2'd3
  } reg_sel_e;

  localparam logic [4:0] CTRL_RST = 5'h0C;

endpackage

// File: rtl/cart_mmc1_if.sv
// CPU and PPU cartridge-edge bus seen by the mapper. The master side is the
// console (CPU/PPU), the slave side is the cartridge mapper.
interface cart_mmc1_if;

  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [7:0]  prg_d_out;

  logic [13:0] chr_a_in;
  logic        chr_r_nw_in;
  logic [7:0]  chr_d_in;
  logic [7:0]  chr_d_out;

  logic        ciram_nce_out;
  logic        ciram_a10_out;

  modport master (
    output prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
    output chr_a_in, chr_r_nw_in, chr_d_in,
    input  prg_d_out, chr_d_out, ciram_nce_out, ciram_a10_out
  );

  modport slave (
    input  prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
    input  chr_a_in, chr_r_nw_in, chr_d_in,
    output prg_d_out, chr_d_out, ciram_nce_out, ciram_a10_out
  );

endinterface

// File: rtl/mmc1_serial_regs.sv
// Serial register port of the mapper: detects CPU write edges, shifts data in
// LSB-first and loads one of four 5-bit registers on every fifth bit.
module mmc1_serial_regs
  import cart_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       i_wr,
  input  logic       i_reset_bit,
  input  logic       i_data_bit,
  input  logic [1:0] i_sel,
  output logic [4:0] o_ctrl,
  output logic [4:0] o_chr0,
  output logic [4:0] o_chr1,
  output logic [4:0] o_prg
);

  logic       r_wr_prev;
  logic [2:0] r_count;
  logic [4:0] r_shift;
  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;

  logic       w_event;
  logic       w_last;
  logic [4:0] w_value;

  assign w_event = i_wr & ~r_wr_prev;
  assign w_last  = (r_count == 3'd4);
  assign w_value = {i_data_bit, r_shift[4:1]};

  // r_wr_prev resets high so a strobe already active when reset releases
  // must drop and rise again before it counts.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_wr_prev <= 1'b1;
      r_count   <= 3'd0;
      r_shift   <= 5'd0;
      r_ctrl    <= CTRL_RST;
      r_chr0    <= 5'd0;
      r_chr1    <= 5'd0;
      r_prg     <= 5'd0;
    end else begin
      r_wr_prev <= i_wr;
      if (w_event) begin
        if (i_reset_bit) begin
          r_count     <= 3'd0;
          r_shift     <= 5'd0;
          r_ctrl[3:2] <= 2'b11;
        end else if (w_last) begin
          r_count <= 3'd0;
          r_shift <= 5'd0;
          case (reg_sel_e'(i_sel))
            REG_CTRL: r_ctrl <= w_value;
            REG_CHR0: r_chr0 <= w_value;
            REG_CHR1: r_chr1 <= w_value;
            REG_PRG:  r_prg  <= w_value;
            default:  r_prg  <= r_prg;
          endcase
        end else begin
          r_count <= r_count + 3'd1;
          r_shift <= w_value;
        end
      end
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_chr0 = r_chr0;
  assign o_chr1 = r_chr1;
  assign o_prg  = r_prg;

endmodule

// File: rtl/cart_mmc1.sv
// MMC1-class cartridge mapper top: translates CPU/PPU addresses into banked
// PRG/CHR memory addresses and drives CIRAM select and A10.
module cart_mmc1
  import cart_pkg::*;
#(
  parameter int PRG_BANKS_LOG2 = 3,
  parameter int CHR_BANKS_LOG2 = 3,
  parameter bit CHR_IS_RAM     = 1'b0
) (
  input  logic                        clk_sys,
  input  logic                        rst,
  output logic                        rst_out,
  cart_mmc1_if.slave                  bus,
  output logic [14+PRG_BANKS_LOG2-1:0] prg_mem_a,
  input  logic [7:0]                  prg_mem_dout,
  output logic [12+CHR_BANKS_LOG2-1:0] chr_mem_a,
  input  logic [7:0]                  chr_mem_dout,
  output logic                        chr_mem_we
);

  localparam int PB = PRG_BANKS_LOG2;
  localparam int CB = CHR_BANKS_LOG2;

  logic [4:0]    w_ctrl;
  logic [4:0]    w_chr0;
  logic [4:0]    w_chr1;
  logic [4:0]    w_prg;
  logic          w_wr;
  logic          w_a14;
  logic          w_a12;
  logic          w_ciram_nce;
  logic [PB-1:0] w_prg_b;
  logic [PB-1:0] w_prg_bank;
  logic [CB-1:0] w_c0;
  logic [CB-1:0] w_c1;
  logic [CB-1:0] w_chr_bank;
  logic          w_a10;
  logic          w_unused_bits;

  assign w_wr = ~bus.prg_nce_in & ~bus.prg_r_nw_in;

  mmc1_serial_regs u_regs (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .i_wr        (w_wr),
    .i_reset_bit (bus.prg_d_in[7]),
    .i_data_bit  (bus.prg_d_in[0]),
    .i_sel       (bus.prg_a_in[14:13]),
    .o_ctrl      (w_ctrl),
    .o_chr0      (w_chr0),
    .o_chr1      (w_chr1),
    .o_prg       (w_prg)
  );

  assign rst_out = rst;

  assign w_a14   = bus.prg_a_in[14];
  assign w_prg_b = w_prg[PB-1:0];

  always_comb begin
    w_prg_bank = w_prg_b;
    case (w_ctrl[3:2])
      PRG_32K_A, PRG_32K_B: w_prg_bank = (w_prg_b & ~PB'(1)) | PB'(w_a14);
      PRG_FIX_FIRST:        w_prg_bank = w_a14 ? w_prg_b : '0;
      PRG_FIX_LAST:         w_prg_bank = w_a14 ? '1 : w_prg_b;
      default:              w_prg_bank = w_prg_b;
    endcase
  end

  assign prg_mem_a     = {w_prg_bank, bus.prg_a_in[13:0]};
  assign bus.prg_d_out = prg_mem_dout & {8{~bus.prg_nce_in}};

  assign w_a12 = bus.chr_a_in[12];
  assign w_c0  = w_chr0[CB-1:0];
  assign w_c1  = w_chr1[CB-1:0];

  // In 8 KB mode the low bank bit comes from PPU A12, not from chr0.
  always_comb begin
    w_chr_bank = (w_c0 & ~CB'(1)) | CB'(w_a12);
    if (w_ctrl[4]) begin
      w_chr_bank = w_a12 ? w_c1 : w_c0;
    end
  end

  assign chr_mem_a = {w_chr_bank, bus.chr_a_in[11:0]};

  always_comb begin
    w_a10 = 1'b0;
    case (w_ctrl[1:0])
      MIR_ONE_LO: w_a10 = 1'b0;
      MIR_ONE_HI: w_a10 = 1'b1;
      MIR_VERT:   w_a10 = bus.chr_a_in[10];
      MIR_HORZ:   w_a10 = bus.chr_a_in[11];
      default:    w_a10 = 1'b0;
    endcase
  end

  assign w_ciram_nce       = ~bus.chr_a_in[13];
  assign bus.ciram_nce_out = w_ciram_nce;
  assign bus.ciram_a10_out = w_a10;
  assign bus.chr_d_out     = chr_mem_dout & {8{w_ciram_nce}};
  assign chr_mem_we        = CHR_IS_RAM & ~bus.chr_r_nw_in & ~bus.chr_a_in[13];

  // PPU write data goes straight to the memory outside; unused data/bank bits here.
  assign w_unused_bits = ^{bus.prg_d_in[6:1], bus.chr_d_in, w_prg, w_chr0, w_chr1};

endmodule

// File: tb/tb_cart_mmc1.sv
// Randomized bench for cart_mmc1 with a behavioural mapper model.
module tb_cart_mmc1;

  localparam int P = 3;
  localparam int C = 3;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        rst_out;
  logic [16:0] prg_mem_a;
  logic [7:0]  prg_mem_dout;
  logic [14:0] chr_mem_a;
  logic [7:0]  chr_mem_dout;
  logic        chr_mem_we;

  cart_mmc1_if bus();

  cart_mmc1 #(
    .PRG_BANKS_LOG2(P),
    .CHR_BANKS_LOG2(C),
    .CHR_IS_RAM    (1'b1)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .rst_out      (rst_out),
    .bus          (bus),
    .prg_mem_a    (prg_mem_a),
    .prg_mem_dout (prg_mem_dout),
    .chr_mem_a    (chr_mem_a),
    .chr_mem_dout (chr_mem_dout),
    .chr_mem_we   (chr_mem_we)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_sh;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_cnt = 0; m_sh = 0;
  endtask

  task automatic model_write(input int a, input int d);
    if (d >= 128) begin
      m_cnt = 0; m_sh = 0; m_ctrl = m_ctrl | 12;
    end else begin
      m_sh = m_sh + ((d % 2) << m_cnt);
      m_cnt++;
      if (m_cnt == 5) begin
        case ((a / 8192) % 4)
          0: m_ctrl = m_sh;
          1: m_chr0 = m_sh;
          2: m_chr1 = m_sh;
          default: m_prg = m_sh;
        endcase
        m_cnt = 0; m_sh = 0;
      end
    end
  endtask

  function automatic int exp_prg(input int a);
    int b, mode, a14, bank;
    b = m_prg % (1 << P);
    mode = (m_ctrl / 4) % 4;
    a14 = (a / 16384) % 2;
    if (mode < 2)       bank = (b / 2) * 2 + a14;
    else if (mode == 2) bank = a14 ? b : 0;
    else                bank = a14 ? (1 << P) - 1 : b;
    return bank * 16384 + a % 16384;
  endfunction

  function automatic int exp_chr(input int a);
    int a12, bank;
    a12 = (a / 4096) % 2;
    if ((m_ctrl / 16) % 2 == 1) bank = a12 ? m_chr1 % (1 << C) : m_chr0 % (1 << C);
    else                        bank = ((m_chr0 % (1 << C)) / 2) * 2 + a12;
    return bank * 4096 + a % 4096;
  endfunction

  function automatic int exp_a10(input int a);
    case (m_ctrl % 4)
      0: return 0;
      1: return 1;
      2: return (a / 1024) % 2;
      default: return (a / 2048) % 2;
    endcase
  endfunction

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int hold);
    @(negedge clk_sys);
    bus.prg_a_in    = a;
    bus.prg_d_in    = d;
    bus.prg_nce_in  = 1'b0;
    bus.prg_r_nw_in = 1'b0;
    repeat (hold) @(negedge clk_sys);
    bus.prg_nce_in  = 1'b1;
    bus.prg_r_nw_in = 1'b1;
    model_write(int'(a), int'(d));
  endtask

  task automatic write5(input logic [14:0] a, input logic [4:0] val);
    for (int i = 0; i < 5; i++) cpu_write(a, {7'd0, val[i]}, 1);
  endtask

  task automatic probe(input logic [14:0] pa, input logic [13:0] ca, input logic crnw);
    @(negedge clk_sys);
    bus.prg_a_in    = pa;
    bus.prg_nce_in  = 1'b0;
    bus.prg_r_nw_in = 1'b1;
    bus.chr_a_in    = ca;
    bus.chr_r_nw_in = crnw;
    chr_mem_dout    = 8'hA5;
    prg_mem_dout    = 8'h5A;
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [14:0] pa;
    logic [13:0] ca;
    logic        nce, crnw;
    pa   = 15'($urandom);
    ca   = 14'($urandom);
    nce  = 1'($urandom);
    crnw = 1'($urandom);
    @(negedge clk_sys);
    bus.prg_a_in    = pa;
    bus.prg_nce_in  = nce;
    bus.prg_r_nw_in = 1'b1;
    bus.chr_a_in    = ca;
    bus.chr_r_nw_in = crnw;
    prg_mem_dout    = 8'($urandom);
    chr_mem_dout    = 8'($urandom);
    #1;
    check_eq({tag, "/prg_a"}, 32'(prg_mem_a), exp_prg(int'(pa)));
    check_eq({tag, "/chr_a"}, 32'(chr_mem_a), exp_chr(int'(ca)));
    check_eq({tag, "/a10"}, 32'(bus.ciram_a10_out), exp_a10(int'(ca)));
    check_eq({tag, "/ciram_nce"}, 32'(bus.ciram_nce_out), ca[13] ? 0 : 1);
    check_eq({tag, "/chr_we"}, 32'(chr_mem_we), (!crnw && !ca[13]) ? 1 : 0);
    check_eq({tag, "/prg_d"}, 32'(bus.prg_d_out), nce ? 0 : int'(prg_mem_dout));
    check_eq({tag, "/chr_d"}, 32'(bus.chr_d_out), ca[13] ? 0 : int'(chr_mem_dout));
    check_eq({tag, "/rst_out"}, 32'(rst_out), 32'(rst));
  endtask

  initial begin
    bus.prg_nce_in  = 1'b1;
    bus.prg_r_nw_in = 1'b1;
    bus.prg_a_in    = '0;
    bus.prg_d_in    = '0;
    bus.chr_a_in    = '0;
    bus.chr_r_nw_in = 1'b1;
    bus.chr_d_in    = '0;
    prg_mem_dout    = '0;
    chr_mem_dout    = '0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;

    probe(15'h7FFC, 14'h0400, 1'b1);
    check_eq("rst_prg_fffc", 32'(prg_mem_a), 32'h1FFFC);
    check_eq("rst_a10_lo", 32'(bus.ciram_a10_out), 0);
    check_all("reset");

    write5(15'h6000, 5'h03);
    probe(15'h0123, 14'h0000, 1'b1);
    check_eq("prg3_8123", 32'(prg_mem_a), 32'h0C123);
    check_all("prg3");

    cpu_write(15'h0000, 8'h00, 1);
    cpu_write(15'h0000, 8'h00, 1);
    cpu_write(15'h0000, 8'h80, 1);
    write5(15'h0000, 5'h11);
    probe(15'h0123, 14'h0000, 1'b1);
    check_eq("ctrl11_a10", 32'(bus.ciram_a10_out), 1);
    check_eq("ctrl11_prg32k", 32'(prg_mem_a), 32'h08123);
    check_all("ctrl11");

    // chr1 = 5 with the first bit on a 10-cycle strobe
    cpu_write(15'h4000, 8'h01, 10);
    cpu_write(15'h4000, 8'h00, 1);
    cpu_write(15'h4000, 8'h01, 1);
    cpu_write(15'h4000, 8'h00, 1);
    probe(15'h0000, 14'h1010, 1'b1);
    check_eq("long_not_yet", 32'(chr_mem_a), 32'h0010);
    cpu_write(15'h4000, 8'h00, 1);
    probe(15'h0000, 14'h1010, 1'b1);
    check_eq("long_loaded", 32'(chr_mem_a), 32'h5010);

    write5(15'h2000, 5'h02);
    write5(15'h0000, 5'h13);
    probe(15'h0000, 14'h0010, 1'b1);
    check_eq("chr4k_lo", 32'(chr_mem_a), 32'h2010);
    probe(15'h0000, 14'h1010, 1'b1);
    check_eq("chr4k_hi", 32'(chr_mem_a), 32'h5010);
    probe(15'h0000, 14'h2800, 1'b1);
    check_eq("horz_a10", 32'(bus.ciram_a10_out), 1);
    check_eq("horz_nce", 32'(bus.ciram_nce_out), 0);
    check_eq("horz_chr_d", 32'(bus.chr_d_out), 0);
    check_all("ctrl13");

    // reset bit on the 5th write: prg stays 3, PRG mode forced to fix-last
    for (int i = 0; i < 4; i++) cpu_write(15'h6000, 8'h01, 1);
    cpu_write(15'h6000, 8'h80, 1);
    probe(15'h4000, 14'h0000, 1'b1);
    check_eq("rst5_fixlast", 32'(prg_mem_a), 32'h1C000);
    probe(15'h0000, 14'h0000, 1'b1);
    check_eq("rst5_prg_kept", 32'(prg_mem_a), 32'h0C000);
    check_all("rst5");

    for (int i = 0; i < 3; i++) cpu_write(15'h6000, 8'h01, 1);
    @(negedge clk_sys);
    rst = 1'b1;
    model_reset();
    probe(15'h0000, 14'h1010, 1'b1);
    check_eq("midrst_prg", 32'(prg_mem_a), 32'h00000);
    check_eq("midrst_chr", 32'(chr_mem_a), 32'h1010);
    check_all("midrst");
    @(negedge clk_sys);
    rst = 1'b0;
    write5(15'h6000, 5'h02);
    probe(15'h0000, 14'h0000, 1'b1);
    check_eq("postrst_prg2", 32'(prg_mem_a), 32'h08000);

    // strobe already active when reset releases must not count
    @(negedge clk_sys);
    rst = 1'b1;
    model_reset();
    bus.prg_a_in    = 15'h6000;
    bus.prg_d_in    = 8'h01;
    bus.prg_nce_in  = 1'b0;
    bus.prg_r_nw_in = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    repeat (3) @(negedge clk_sys);
    bus.prg_nce_in  = 1'b1;
    bus.prg_r_nw_in = 1'b1;
    write5(15'h6000, 5'h01);
    probe(15'h0000, 14'h0000, 1'b1);
    check_eq("pending_prg1", 32'(prg_mem_a), 32'h04000);

    probe(15'h0000, 14'h1000, 1'b0);
    check_eq("we_ppu_wr", 32'(chr_mem_we), 1);
    probe(15'h0000, 14'h2000, 1'b0);
    check_eq("we_nt_wr", 32'(chr_mem_we), 0);
    probe(15'h0000, 14'h1000, 1'b1);
    check_eq("we_ppu_rd", 32'(chr_mem_we), 0);

    for (int n = 0; n < 300; n++) begin
      logic [14:0] a;
      logic [7:0]  d;
      a = 15'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 1));
      cpu_write(a, d, $urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk_sys);
        rst = 1'b1;
        model_reset();
        @(negedge clk_sys);
        rst = 1'b0;
      end
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
